// File: rtl/store_buffer_pkg.sv
// Shared processor types for the data-side store buffer: cache-facing widths,
// the buffered store record and the single cache-port operation encoding.
package store_buffer_pkg;

  localparam int unsigned SB_AW = 6;
  localparam int unsigned SB_DW = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_READ,
    PORT_WRITE
  } port_op_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding lookup: compares the load address against every
// occupied entry in age order and returns the data of the youngest match.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  sb_entry_t [DEPTH-1:0]        entries,
  input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
  input  logic [$clog2(DEPTH):0]       count,
  input  logic [AW-1:0]                ld_addr,
  output logic                         hit,
  output logic [DW-1:0]                data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < count) && (entries[idx].addr == ld_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between CPU and data cache: loads own the single cache
// port and are forwarded from buffered stores; stores drain in order when idle.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     st_valid_i,
  input  logic [AW-1:0]            st_addr_i,
  input  logic [DW-1:0]            st_dato_i,
  output logic                     st_ready_o,
  input  logic                     ld_req_i,
  input  logic [AW-1:0]            ld_addr_i,
  output logic [DW-1:0]            ld_dato_o,
  output logic                     ld_hit_o,
  output logic [AW-1:0]            mem_addr_o,
  output logic [DW-1:0]            mem_dato_o,
  output logic                     memwrite_o,
  output logic                     memread_o,
  input  logic [DW-1:0]            mem_dato_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  sb_entry_t [DEPTH-1:0] entries;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count_q;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  fwd_hit;
  logic [DW-1:0]         fwd_data;
  port_op_t              op;

  // While reset is held the outputs already look like an empty buffer.
  assign full       = (count_q == (PW+1)'(DEPTH));
  assign empty      = rst_i || (count_q == '0);
  assign st_ready_o = rst_i || !full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign push       = st_valid_i && st_ready_o;
  assign pop        = (op == PORT_WRITE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      entries[wr_ptr].addr <= st_addr_i;
      entries[wr_ptr].data <= st_dato_i;
    end
  end

  always_comb begin
    op = PORT_IDLE;
    if (ld_req_i)    op = PORT_READ;
    else if (!empty) op = PORT_WRITE;
  end

  always_comb begin
    mem_addr_o = '0;
    mem_dato_o = '0;
    memwrite_o = 1'b0;
    memread_o  = 1'b0;
    case (op)
      PORT_READ: begin
        mem_addr_o = ld_addr_i;
        memread_o  = 1'b1;
      end
      PORT_WRITE: begin
        mem_addr_o = entries[rd_ptr].addr;
        mem_dato_o = entries[rd_ptr].data;
        memwrite_o = 1'b1;
      end
      default: ;
    endcase
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .entries (entries),
    .rd_ptr  (rd_ptr),
    .count   (count_q),
    .ld_addr (ld_addr_i),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  always_comb begin
    ld_hit_o  = 1'b0;
    ld_dato_o = '0;
    if (ld_req_i) begin
      ld_hit_o  = fwd_hit && !rst_i;
      ld_dato_o = ld_hit_o ? fwd_data : mem_dato_i;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue of expected drains models the
// buffer, and every cycle's outputs are compared against it.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_dato;
  logic          st_ready;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_dato;
  logic          ld_hit;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dato_o;
  logic          memwrite;
  logic          memread;
  logic [DW-1:0] mem_dato_i;
  logic [2:0]    count;
  logic          empty;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .st_valid_i (st_valid),
    .st_addr_i  (st_addr),
    .st_dato_i  (st_dato),
    .st_ready_o (st_ready),
    .ld_req_i   (ld_req),
    .ld_addr_i  (ld_addr),
    .ld_dato_o  (ld_dato),
    .ld_hit_o   (ld_hit),
    .mem_addr_o (mem_addr),
    .mem_dato_o (mem_dato_o),
    .memwrite_o (memwrite),
    .memread_o  (memread),
    .mem_dato_i (mem_dato_i),
    .count_o    (count),
    .empty_o    (empty)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs are already applied; compare at the falling edge, then advance the model.
  task automatic cycle();
    logic          eh;
    logic [DW-1:0] ed;
    logic          accept;
    @(negedge clk);
    if (rst) begin
      check("rst_ready", 64'(st_ready), 64'd1);
      check("rst_memwrite", 64'(memwrite), 64'd0);
      check("rst_hit", 64'(ld_hit), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
    end else begin
      check("count", 64'(count), 64'(sb.size()));
      check("empty", 64'(empty), 64'(sb.size() == 0));
      check("st_ready", 64'(st_ready), 64'(sb.size() != DEPTH));
      if (ld_req) begin
        eh = 1'b0;
        ed = mem_dato_i;
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].a == ld_addr) begin
            eh = 1'b1;
            ed = sb[i].d;
            break;
          end
        end
        check("ld_hit", 64'(ld_hit), 64'(eh));
        check("ld_dato", 64'(ld_dato), 64'(ed));
        check("ld_memread", 64'(memread), 64'd1);
        check("ld_memwrite", 64'(memwrite), 64'd0);
        check("ld_mem_addr", 64'(mem_addr), 64'(ld_addr));
      end else begin
        check("idle_hit", 64'(ld_hit), 64'd0);
        check("idle_ld_dato", 64'(ld_dato), 64'd0);
        check("memread", 64'(memread), 64'd0);
        if (sb.size() > 0) begin
          check("drain_we", 64'(memwrite), 64'd1);
          check("drain_addr", 64'(mem_addr), 64'(sb[0].a));
          check("drain_data", 64'(mem_dato_o), 64'(sb[0].d));
        end else begin
          check("empty_we", 64'(memwrite), 64'd0);
          check("empty_addr", 64'(mem_addr), 64'd0);
          check("empty_data", 64'(mem_dato_o), 64'd0);
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      accept = st_valid && (sb.size() != DEPTH);
      if (!ld_req && sb.size() > 0) void'(sb.pop_front());
      if (accept) sb.push_back('{st_addr, st_dato});
    end
    #1;
  endtask

  task automatic drive(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic lr, input logic [AW-1:0] la);
    st_valid = sv;
    st_addr  = sa;
    st_dato  = sd;
    ld_req   = lr;
    ld_addr  = la;
    cycle();
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_dato = '0;
    ld_req = 1'b0; ld_addr = '0; mem_dato_i = 32'h0BAD_F00D;
    cycle();
    cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Single store drains on the following cycle, then the buffer is empty.
    drive(1, 6'h05, 32'hAAAA_0001, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Two stores to one address under a held load: youngest data forwarded.
    drive(1, 6'h10, 32'd1, 1, 6'h10);
    drive(1, 6'h10, 32'd2, 1, 6'h10);
    drive(0, 0, 0, 1, 6'h10);
    drive(0, 0, 0, 1, 6'h10);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Miss on an unbuffered address returns cache data.
    mem_dato_i = 32'hDEAD_BEEF;
    drive(0, 0, 0, 1, 6'h3F);

    // Loads stall the drain: four stores fill, fifth is refused, then in-order drain.
    for (int i = 0; i < 5; i++) drive(1, 6'(6'h20 + i), 32'h5000_0000 + i, 1, 6'h3F);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0);

    // Push and drain together at count 2 keep the count at 2.
    drive(1, 6'h01, 32'h11, 1, 6'h01);
    drive(1, 6'h02, 32'h22, 1, 6'h02);
    drive(1, 6'h03, 32'h33, 0, 0);
    drive(1, 6'h04, 32'h44, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Enough traffic to wrap the pointers several times.
    for (int i = 0; i < 10; i++) drive(1, 6'(i), 32'h0100 + i, (i % 3) == 1, 6'(i - 1));
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0);

    // Mixed random traffic on a narrow address range to exercise forwarding.
    for (int i = 0; i < 80; i++) begin
      mem_dato_i = $urandom;
      drive(1'($urandom_range(0, 1)), 6'(6'h30 + $urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 2) == 0), 6'(6'h30 + $urandom_range(0, 3)));
    end
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0);

    // Reset with three pending stores discards them.
    for (int i = 0; i < 3; i++) drive(1, 6'(6'h38 + i), 32'hCC00 + i, 1, 6'h00);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
